// File: rtl/projectile_pool_pkg.sv
// Shared types and screen constants for the projectile pool and its slots.
package projectile_pool_pkg;

  typedef logic [10:0] coordinate;
  typedef logic [7:0]  RGB;

  localparam int SCREEN_W      = 640;
  localparam int SCREEN_H      = 480;
  localparam int SUBPIXEL_BITS = 6;

  // Signed 11.6 fixed point: integer pixel in [16:6], fraction in [5:0].
  typedef logic signed [16:0] fixed_pos;

  function automatic fixed_pos to_fixed(input coordinate px);
    return fixed_pos'({px, {SUBPIXEL_BITS{1'b0}}});
  endfunction

endpackage

// File: rtl/projectile_slot.sv
// One projectile slot: position, activity, per-frame motion with off-screen
// retirement, and a registered "covers this pixel" flag.
module projectile_slot
  import projectile_pool_pkg::*;
#(
  parameter int PROJ_WIDTH  = 2,
  parameter int PROJ_HEIGHT = 5,
  parameter int X_SPEED     = 0,
  parameter int Y_SPEED     = -256
) (
  input  logic      clk,
  input  logic      resetN,
  input  logic      launch_i,
  input  logic      move_i,
  input  logic      clear_i,
  input  fixed_pos  launch_x_i,
  input  fixed_pos  launch_y_i,
  input  coordinate pixel_x_i,
  input  coordinate pixel_y_i,
  output logic      active_o,
  output logic      slot_dr_o
);

  localparam fixed_pos          X_STEP = fixed_pos'(X_SPEED);
  localparam fixed_pos          Y_STEP = fixed_pos'(Y_SPEED);
  localparam logic signed [10:0] X_MAX = 11'(SCREEN_W - PROJ_WIDTH);
  localparam logic signed [10:0] Y_MAX = 11'(SCREEN_H - PROJ_HEIGHT);
  localparam logic signed [12:0] W_EXT = 13'(PROJ_WIDTH);
  localparam logic signed [12:0] H_EXT = 13'(PROJ_HEIGHT);

  logic     active_q, active_d;
  logic     dr_q, dr_d;
  fixed_pos x_q, x_d, y_q, y_d;

  fixed_pos           x_mv, y_mv;
  logic signed [10:0] xm_int, ym_int;
  logic signed [12:0] px, py, xl, yl;
  logic               off_screen;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    active_d = active_q;
    x_d      = x_q;
    y_d      = y_q;

    x_mv   = x_q + X_STEP;
    y_mv   = y_q + Y_STEP;
    xm_int = x_mv[16:6];
    ym_int = y_mv[16:6];
    off_screen = (xm_int < 0) || (xm_int > X_MAX) || (ym_int < 0) || (ym_int > Y_MAX);

    // Launch only targets a free slot; collision clear wins over motion.
    if (launch_i) begin
      active_d = 1'b1;
      x_d      = launch_x_i;
      y_d      = launch_y_i;
    end else if (clear_i) begin
      active_d = 1'b0;
    end else if (move_i && active_q) begin
      x_d = x_mv;
      y_d = y_mv;
      if (off_screen) active_d = 1'b0;
    end

    px   = $signed({2'b00, pixel_x_i});
    py   = $signed({2'b00, pixel_y_i});
    xl   = {{2{x_q[16]}}, x_q[16:6]};
    yl   = {{2{y_q[16]}}, y_q[16:6]};
    dr_d = active_q && (px >= xl) && (px < xl + W_EXT) && (py >= yl) && (py < yl + H_EXT);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only; the reset here is synchronous.
    if (!resetN) begin
      active_q <= 1'b0;
      dr_q     <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      active_q <= active_d;
      dr_q     <= dr_d;
      x_q      <= x_d;
      y_q      <= y_d;
    end
  end

  assign active_o  = active_q;
  assign slot_dr_o = dr_q;

endmodule

// File: rtl/projectile_pool.sv
// Pool of SHOT_AMOUNT projectile slots: allocation, fire-rate limiting,
// occupancy count and merged draw request. Optional macro: PROJECTILE_COOLDOWN_EN.
module projectile_pool
  import projectile_pool_pkg::*;
#(
  parameter int SHOT_AMOUNT     = 7,
  parameter int PROJ_WIDTH      = 2,
  parameter int PROJ_HEIGHT     = 5,
  parameter int X_SPEED         = 0,
  parameter int Y_SPEED         = -256,
  parameter int X_OFFSET        = 15,
  parameter int Y_OFFSET        = 0,
  parameter int COOLDOWN_FRAMES = 8,
  parameter RGB PROJ_COLOR      = 8'h1F,
  localparam int CNT_W          = $clog2(SHOT_AMOUNT + 1)
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             startOfFrame,
  input  logic             shooting_pulse,
  input  logic             collision,
  input  coordinate        pixelX,
  input  coordinate        pixelY,
  input  coordinate        spaceShip_X,
  input  coordinate        spaceShip_Y,
  output logic             projectileDR,
  output RGB               projectileRGB,
  output logic [CNT_W-1:0] active_count,
  output logic             shot_dropped
);

  logic [SHOT_AMOUNT-1:0] active, slot_dr, launch_vec;
  logic                   any_free, accept, cooldown_ok;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   dropped_q;
  fixed_pos               launch_x, launch_y;

  // Allocation looks at the pre-clock active vector only.
  always_comb begin
    launch_vec = '0;
    any_free   = 1'b0;
    for (int i = 0; i < SHOT_AMOUNT; i++) begin
      if (!active[i] && !any_free) begin
        launch_vec[i] = 1'b1;
        any_free      = 1'b1;
      end
    end
  end

`ifdef PROJECTILE_COOLDOWN_EN
  localparam int CD_W = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  logic [CD_W-1:0] cooldown_q, cooldown_d;

  always_comb begin
    cooldown_d = cooldown_q;
    if (accept)                                cooldown_d = CD_W'(COOLDOWN_FRAMES);
    else if (startOfFrame && cooldown_q != '0) cooldown_d = cooldown_q - CD_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetN) cooldown_q <= '0;
    else         cooldown_q <= cooldown_d;
  end

  assign cooldown_ok = (cooldown_q == '0);
`else
  logic [31:0] unused_cooldown_cfg;
  assign unused_cooldown_cfg = COOLDOWN_FRAMES;
  assign cooldown_ok         = 1'b1;
`endif

  assign accept   = shooting_pulse && any_free && cooldown_ok;
  assign launch_x = to_fixed(coordinate'(spaceShip_X + coordinate'(X_OFFSET)));
  assign launch_y = to_fixed(coordinate'(spaceShip_Y + coordinate'(Y_OFFSET)));

  for (genvar g = 0; g < SHOT_AMOUNT; g++) begin : g_slot
    projectile_slot #(
      .PROJ_WIDTH (PROJ_WIDTH),
      .PROJ_HEIGHT(PROJ_HEIGHT),
      .X_SPEED    (X_SPEED),
      .Y_SPEED    (Y_SPEED)
    ) u_slot (
      .clk       (clk),
      .resetN    (resetN),
      .launch_i  (accept && launch_vec[g]),
      .move_i    (startOfFrame),
      .clear_i   (collision && slot_dr[g]),
      .launch_x_i(launch_x),
      .launch_y_i(launch_y),
      .pixel_x_i (pixelX),
      .pixel_y_i (pixelY),
      .active_o  (active[g]),
      .slot_dr_o (slot_dr[g])
    );
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < SHOT_AMOUNT; i++) count_d = count_d + CNT_W'(active[i]);
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      count_q   <= '0;
      dropped_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      dropped_q <= shooting_pulse && !accept;
    end
  end

  assign active_count  = count_q;
  assign shot_dropped  = dropped_q;
  assign projectileDR  = |slot_dr;
  assign projectileRGB = PROJ_COLOR;

endmodule
